// File: rtl/timing_pkg.sv
// Shared encodings for the timing sequencer: mode bit, latched-code source and T-state numbers.
package timing_pkg;

    typedef enum logic {
        MODE_ADDRESS     = 1'b0,
        MODE_INSTRUCTION = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        INT_NONE = 2'b00,
        INT_IRQ  = 2'b01,
        INT_NMI  = 2'b10
    } int_src_t;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;

endpackage

// File: rtl/timing_sequencer_if.sv
// Decoder-side inputs and control-ROM-side outputs of the timing sequencer.
interface timing_sequencer_if #(
    parameter int INSTR_W = 6,
    parameter int ADDR_W  = 4,
    parameter int T_W     = 3
);
    logic               enable;
    logic               no_addressing;
    logic               end_addressing;
    logic               get_instruction;
    logic [INSTR_W-1:0] decoded_instruction;
    logic [ADDR_W-1:0]  decoded_address;
    logic               nmi_req;
    logic               irq_req;
    logic               irq_mask;
    logic [INSTR_W-1:0] current_instruction;
    logic [ADDR_W-1:0]  current_address;
    logic [T_W-1:0]     time_state;
    logic               mode;
    logic [1:0]         int_source;
    logic               nmi_ack;
    logic               irq_ack;
    logic               timeout;

    modport master (
        output enable, no_addressing, end_addressing, get_instruction,
        output decoded_instruction, decoded_address, nmi_req, irq_req, irq_mask,
        input  current_instruction, current_address, time_state, mode,
        input  int_source, nmi_ack, irq_ack, timeout
    );

    modport slave (
        input  enable, no_addressing, end_addressing, get_instruction,
        input  decoded_instruction, decoded_address, nmi_req, irq_req, irq_mask,
        output current_instruction, current_address, time_state, mode,
        output int_source, nmi_ack, irq_ack, timeout
    );
endinterface

// File: rtl/timing_sequencer_int_arbiter.sv
// NMI edge capture, pending flag and NMI-over-IRQ selection for instruction fetch.
module int_arbiter
    import timing_pkg::*;
(
    input  logic     clk,
    input  logic     nrst,
    input  logic     enable,
    input  logic     fetch,
    input  logic     nmi_req,
    input  logic     irq_req,
    input  logic     irq_mask,
    output int_src_t sel,
    output logic     nmi_ack,
    output logic     irq_ack
);
    logic nmi_prev_reg;
    logic nmi_pending_reg;
    logic nmi_ack_reg;
    logic irq_ack_reg;
    logic nmi_edge;
    logic take_nmi;
    logic take_irq;

    assign nmi_edge = nmi_req & ~nmi_prev_reg;
    assign take_nmi = enable & fetch & nmi_pending_reg;
    assign take_irq = enable & fetch & ~nmi_pending_reg & irq_req & ~irq_mask;

    always_comb begin
        sel = INT_NONE;
        if (take_nmi)
            sel = INT_NMI;
        else if (take_irq)
            sel = INT_IRQ;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            nmi_prev_reg    <= 1'b0;
            nmi_pending_reg <= 1'b0;
            nmi_ack_reg     <= 1'b0;
            irq_ack_reg     <= 1'b0;
        end else begin
            nmi_prev_reg    <= nmi_req;
            // A fresh edge wins over the service clear so it is not lost.
            nmi_pending_reg <= nmi_edge | (nmi_pending_reg & ~take_nmi);
            nmi_ack_reg     <= take_nmi;
            irq_ack_reg     <= take_irq;
        end
    end

    assign nmi_ack = nmi_ack_reg;
    assign irq_ack = irq_ack_reg;
endmodule

// File: rtl/timing_sequencer.sv
// ADDRESS/INSTRUCTION mode and T-state sequencer with instruction/addressing latch and interrupt injection.
module timing_sequencer
    import timing_pkg::*;
#(
    parameter int                 INSTR_W   = 6,
    parameter int                 ADDR_W    = 4,
    parameter int                 T_W       = 3,
    parameter int                 T_MAX     = T6,
    parameter logic [INSTR_W-1:0] NMI_INSTR = 6'd62,
    parameter logic [INSTR_W-1:0] IRQ_INSTR = 6'd63,
    parameter logic [ADDR_W-1:0]  INT_ADDR  = 4'd0
) (
    input  logic               clk,
    input  logic               nrst,
    timing_sequencer_if.slave  bus
);
    mode_t              mode_reg;
    logic [T_W-1:0]     time_state_reg;
    logic               timeout_reg;
    logic [INSTR_W-1:0] current_instruction_reg;
    logic [ADDR_W-1:0]  current_address_reg;
    int_src_t           int_source_reg;
    int_src_t           sel;

    int_arbiter u_int_arbiter (
        .clk      (clk),
        .nrst     (nrst),
        .enable   (bus.enable),
        .fetch    (bus.get_instruction),
        .nmi_req  (bus.nmi_req),
        .irq_req  (bus.irq_req),
        .irq_mask (bus.irq_mask),
        .sel      (sel),
        .nmi_ack  (bus.nmi_ack),
        .irq_ack  (bus.irq_ack)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            mode_reg                <= MODE_ADDRESS;
            time_state_reg          <= T_W'(T0);
            timeout_reg             <= 1'b0;
            current_instruction_reg <= '0;
            current_address_reg     <= '0;
            int_source_reg          <= INT_NONE;
        end else if (bus.enable) begin
            if (bus.end_addressing | bus.no_addressing) begin
                mode_reg       <= MODE_INSTRUCTION;
                time_state_reg <= T_W'(T0);
            end else if (bus.get_instruction) begin
                mode_reg       <= MODE_ADDRESS;
                time_state_reg <= T_W'(T0);
            end else if (time_state_reg < T_W'(T_MAX)) begin
                time_state_reg <= time_state_reg + 1'b1;
            end else begin
                timeout_reg <= 1'b1;
            end

            // The latch keys on get_instruction alone, even when end_addressing wins the mode transition.
            if (bus.get_instruction) begin
                int_source_reg <= sel;
                case (sel)
                    INT_NMI: begin
                        current_instruction_reg <= NMI_INSTR;
                        current_address_reg     <= INT_ADDR;
                    end
                    INT_IRQ: begin
                        current_instruction_reg <= IRQ_INSTR;
                        current_address_reg     <= INT_ADDR;
                    end
                    default: begin
                        current_instruction_reg <= bus.decoded_instruction;
                        current_address_reg     <= bus.decoded_address;
                    end
                endcase
            end
        end
    end

    assign bus.mode                = mode_reg;
    assign bus.time_state          = time_state_reg;
    assign bus.timeout             = timeout_reg;
    assign bus.current_instruction = current_instruction_reg;
    assign bus.current_address     = current_address_reg;
    assign bus.int_source          = int_source_reg;
endmodule

// File: tb/tb_timing_sequencer.sv
// Directed vector table plus randomized run against a cycle-level reference model of the sequencer.
module tb_timing_sequencer;
    import timing_pkg::*;

    localparam int MODEL_T_MAX = 6;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    timing_sequencer_if #(.INSTR_W(6), .ADDR_W(4), .T_W(3)) bus ();

    timing_sequencer #(.INSTR_W(6), .ADDR_W(4), .T_W(3), .T_MAX(6)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_mode, m_t, m_ci, m_ca, m_src, m_nack, m_iack, m_to, m_pend, m_prev;

    typedef struct {
        int rn, en, na, ea, gi, di, da, nmi, irq, mask;
        int md, t, ci, ca, src, nk, ik, to;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input int rn, en, na, ea, gi, di, da, nmi, irq, mask,
                               input int md, t, ci, ca, src, nk, ik, to);
        vec_t r;
        r.rn = rn; r.en = en; r.na = na; r.ea = ea; r.gi = gi; r.di = di; r.da = da;
        r.nmi = nmi; r.irq = irq; r.mask = mask;
        r.md = md; r.t = t; r.ci = ci; r.ca = ca; r.src = src; r.nk = nk; r.ik = ik; r.to = to;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        nrst                    = 1'(x.rn);
        bus.enable              = 1'(x.en);
        bus.no_addressing       = 1'(x.na);
        bus.end_addressing      = 1'(x.ea);
        bus.get_instruction     = 1'(x.gi);
        bus.decoded_instruction = 6'(x.di);
        bus.decoded_address     = 4'(x.da);
        bus.nmi_req             = 1'(x.nmi);
        bus.irq_req             = 1'(x.irq);
        bus.irq_mask            = 1'(x.mask);
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_ci = 0; m_ca = 0; m_src = 0;
        m_nack = 0; m_iack = 0; m_to = 0; m_pend = 0; m_prev = 0;
    endtask

    // Next state from the current inputs, computed before the edge that applies them.
    task automatic model_step();
        int nmi_edge;
        if (!nrst) begin
            model_reset();
        end else begin
            nmi_edge = (bus.nmi_req && m_prev == 0) ? 1 : 0;
            m_prev = int'(bus.nmi_req);
            m_nack = 0;
            m_iack = 0;
            if (bus.enable) begin
                if (bus.end_addressing || bus.no_addressing) begin
                    m_mode = 1; m_t = 0;
                end else if (bus.get_instruction) begin
                    m_mode = 0; m_t = 0;
                end else if (m_t < MODEL_T_MAX) begin
                    m_t = m_t + 1;
                end else begin
                    m_to = 1;
                end
                if (bus.get_instruction) begin
                    if (m_pend != 0) begin
                        m_ci = 62; m_ca = 0; m_src = 2; m_nack = 1; m_pend = 0;
                    end else if (bus.irq_req && !bus.irq_mask) begin
                        m_ci = 63; m_ca = 0; m_src = 1; m_iack = 1;
                    end else begin
                        m_ci = int'(bus.decoded_instruction);
                        m_ca = int'(bus.decoded_address);
                        m_src = 0;
                    end
                end
            end
            if (nmi_edge != 0) m_pend = 1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".model.mode"},    32'(bus.mode),                m_mode);
        chk({tag, ".model.t"},       32'(bus.time_state),          m_t);
        chk({tag, ".model.instr"},   32'(bus.current_instruction), m_ci);
        chk({tag, ".model.addr"},    32'(bus.current_address),     m_ca);
        chk({tag, ".model.src"},     32'(bus.int_source),          m_src);
        chk({tag, ".model.nmi_ack"}, 32'(bus.nmi_ack),             m_nack);
        chk({tag, ".model.irq_ack"}, 32'(bus.irq_ack),             m_iack);
        chk({tag, ".model.timeout"}, 32'(bus.timeout),             m_to);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        vec_t x;
        model_reset();
        x = v(0,0,0,0,0,0,0,0,0,0, 0,T0,0,0,0,0,0,0);
        drive(x);

        // rn en na ea gi di da nmi irq mask | md t ci ca src nk ik to
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,T0,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,T0,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T1,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T2,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T3,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T4,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T5,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T6,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T6,0,0,0,0,0,1));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T6,0,0,0,0,0,1));
        vecs.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,T0,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T1,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T2,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T3,0,0,0,0,0,0));
        vecs.push_back(v(1,1,1,0,0,0,0,0,0,0, 1,T0,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,1,'h15,7,0,0,0, 0,T0,'h15,7,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T1,'h15,7,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,1,0,0, 0,T2,'h15,7,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,1,0,0, 0,T3,'h15,7,0,0,0,0));
        vecs.push_back(v(1,1,0,0,1,'h15,7,1,0,0, 0,T0,62,0,2,1,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T1,62,0,2,0,0,0));
        vecs.push_back(v(1,1,0,0,1,'h0A,3,0,0,0, 0,T0,'h0A,3,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,1,1, 0,T1,'h0A,3,0,0,0,0));
        vecs.push_back(v(1,1,0,0,1,'h11,2,0,1,1, 0,T0,'h11,2,0,0,0,0));
        vecs.push_back(v(1,1,0,0,1,'h11,2,0,1,0, 0,T0,63,0,1,0,1,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T1,63,0,1,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,1,1,0, 0,T2,63,0,1,0,0,0));
        vecs.push_back(v(1,1,0,0,1,'h11,2,1,1,0, 0,T0,62,0,2,1,0,0));
        vecs.push_back(v(1,1,0,0,1,'h11,2,0,1,0, 0,T0,63,0,1,0,1,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T1,63,0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,1,5,1,0,0,0, 0,T1,63,0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,1,5,1,1,0,0, 0,T1,63,0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,1,5,1,1,0,0, 0,T1,63,0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,1,5,1,0,0,0, 0,T1,63,0,1,0,0,0));
        vecs.push_back(v(1,1,0,0,1,5,1,0,0,0, 0,T0,62,0,2,1,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T1,62,0,2,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,1,0,0, 0,T2,62,0,2,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T3,62,0,2,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T4,62,0,2,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T5,62,0,2,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T6,62,0,2,0,0,0));
        vecs.push_back(v(1,1,0,0,0,0,0,0,0,0, 0,T6,62,0,2,0,0,1));
        vecs.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,T0,0,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,1,'h2A,9,0,0,0, 0,T0,'h2A,9,0,0,0,0));
        vecs.push_back(v(1,1,0,1,1,'h33,5,0,0,0, 1,T0,'h33,5,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i]);
            cycle(tag);
            chk({tag, ".mode"},    32'(bus.mode),                vecs[i].md);
            chk({tag, ".t"},       32'(bus.time_state),          vecs[i].t);
            chk({tag, ".instr"},   32'(bus.current_instruction), vecs[i].ci);
            chk({tag, ".addr"},    32'(bus.current_address),     vecs[i].ca);
            chk({tag, ".src"},     32'(bus.int_source),          vecs[i].src);
            chk({tag, ".nmi_ack"}, 32'(bus.nmi_ack),             vecs[i].nk);
            chk({tag, ".irq_ack"}, 32'(bus.irq_ack),             vecs[i].ik);
            chk({tag, ".timeout"}, 32'(bus.timeout),             vecs[i].to);
            $display("vec %0d: mode=%0d t=%0d instr=%0h addr=%0h src=%0d nack=%0d iack=%0d to=%0d",
                     i, bus.mode, bus.time_state, bus.current_instruction, bus.current_address,
                     bus.int_source, bus.nmi_ack, bus.irq_ack, bus.timeout);
        end

        for (int i = 0; i < 1000; i++) begin
            x = v(($urandom_range(0, 63) != 0) ? 1 : 0,
                  ($urandom_range(0, 7) != 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) == 0) ? 1 : 0,
                  int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0,
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  0, 0, 0, 0, 0, 0, 0, 0);
            drive(x);
            cycle($sformatf("rnd%0d", i));
            $display("rnd %0d: nrst=%0d en=%0d gi=%0d nmi=%0d irq=%0d -> mode=%0d t=%0d instr=%0h src=%0d to=%0d",
                     i, x.rn, x.en, x.gi, x.nmi, x.irq, bus.mode, bus.time_state,
                     bus.current_instruction, bus.int_source, bus.timeout);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
